// File: rtl/vj_scan_scheduler.sv
// Viola-Jones scan-window sequencer: settle wait, then one (level,row,col) per valid/ready handshake, drain, done.
// Optional macro VJ_SCHED_STRIDE2_EN steps rows and columns by 2 pixels instead of 1.
module vj_scan_scheduler #(
    parameter int unsigned PYRAMID_LEVELS  = 10,
    parameter int unsigned WINDOW_SIZE     = 24,
    parameter logic [PYRAMID_LEVELS-1:0][31:0] LEVEL_WIDTHS = {
        32'd62, 32'd74, 32'd89, 32'd107, 32'd128, 32'd154, 32'd185, 32'd222, 32'd267, 32'd320},
    parameter logic [PYRAMID_LEVELS-1:0][31:0] LEVEL_HEIGHTS = {
        32'd46, 32'd56, 32'd67, 32'd80, 32'd96, 32'd116, 32'd139, 32'd167, 32'd200, 32'd240},
    parameter int unsigned INT_WAIT_CYCLES = 76800
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        laptop_img_rdy,
    input  logic        win_ready,
    input  logic        pipe_idle,
    output logic        win_valid,
    output logic [3:0]  img_index,
    output logic [31:0] row_index,
    output logic [31:0] col_index,
    output logic        busy,
    output logic        done
);

`ifdef VJ_SCHED_STRIDE2_EN
    localparam int unsigned STEP = 2;
`else
    localparam int unsigned STEP = 1;
`endif
    localparam int unsigned LW = (PYRAMID_LEVELS > 1) ? $clog2(PYRAMID_LEVELS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_INT,
        S_SCAN,
        S_DRAIN
    } state_t;

    state_t         r_state;
    logic [LW-1:0]  r_lvl;
    logic [31:0]    r_wait_cnt;

    logic [31:0]    w_col_max;
    logic [31:0]    w_row_max;
    logic [31:0]    w_col_step;
    logic [31:0]    w_row_step;
    logic           w_col_adv;
    logic           w_row_adv;
    logic           w_last_lvl;
    logic           w_accept;

    // Next-position tests against the current level's last legal window origin.
    assign w_col_max  = LEVEL_WIDTHS[r_lvl]  - 32'(WINDOW_SIZE);
    assign w_row_max  = LEVEL_HEIGHTS[r_lvl] - 32'(WINDOW_SIZE);
    assign w_col_step = col_index + 32'(STEP);
    assign w_row_step = row_index + 32'(STEP);
    assign w_col_adv  = (w_col_step <= w_col_max);
    assign w_row_adv  = (w_row_step <= w_row_max);
    assign w_last_lvl = (r_lvl == LW'(PYRAMID_LEVELS - 1));
    assign w_accept   = win_valid && win_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_lvl      <= '0;
            r_wait_cnt <= '0;
            win_valid  <= 1'b0;
            img_index  <= 4'd15;
            row_index  <= '0;
            col_index  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (laptop_img_rdy) begin
                        r_state    <= S_WAIT_INT;
                        r_wait_cnt <= '0;
                        busy       <= 1'b1;
                    end
                end
                S_WAIT_INT: begin
                    if (r_wait_cnt == 32'(INT_WAIT_CYCLES - 1)) begin
                        r_state   <= S_SCAN;
                        r_lvl     <= '0;
                        win_valid <= 1'b1;
                        img_index <= 4'd0;
                        row_index <= '0;
                        col_index <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 32'd1;
                    end
                end
                S_SCAN: begin
                    // Indices hold whenever the pipeline stalls the handshake.
                    if (w_accept) begin
                        if (w_col_adv) begin
                            col_index <= w_col_step;
                        end else if (w_row_adv) begin
                            col_index <= '0;
                            row_index <= w_row_step;
                        end else if (!w_last_lvl) begin
                            r_lvl     <= r_lvl + LW'(1);
                            img_index <= 4'(r_lvl + LW'(1));
                            row_index <= '0;
                            col_index <= '0;
                        end else begin
                            r_state   <= S_DRAIN;
                            r_lvl     <= '0;
                            win_valid <= 1'b0;
                            img_index <= 4'd15;
                            row_index <= '0;
                            col_index <= '0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pipe_idle) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    win_valid <= 1'b0;
                    img_index <= 4'd15;
                    row_index <= '0;
                    col_index <= '0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vj_scan_scheduler.sv
// Scoreboard bench for vj_scan_scheduler: 2-level pyramid (26x25, 25x24), 24-pixel window, 4-cycle settle.
module tb_vj_scan_scheduler;

    localparam int unsigned LEVELS = 2;
    localparam int unsigned WS     = 24;
    localparam int unsigned WAIT_C = 4;
    localparam logic [LEVELS-1:0][31:0] WIDTHS  = {32'd25, 32'd26};
    localparam logic [LEVELS-1:0][31:0] HEIGHTS = {32'd24, 32'd25};

    typedef struct packed {
        logic [3:0]  lvl;
        logic [31:0] row;
        logic [31:0] col;
    } win_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        laptop_img_rdy;
    logic        win_ready;
    logic        pipe_idle;
    logic        win_valid;
    logic [3:0]  img_index;
    logic [31:0] row_index;
    logic [31:0] col_index;
    logic        busy;
    logic        done;

    int   checks   = 0;
    int   errors   = 0;
    int   cyc      = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    int   hs_cyc   = 0;
    win_t sb[$];

    vj_scan_scheduler #(
        .PYRAMID_LEVELS (LEVELS),
        .WINDOW_SIZE    (WS),
        .LEVEL_WIDTHS   (WIDTHS),
        .LEVEL_HEIGHTS  (HEIGHTS),
        .INT_WAIT_CYCLES(WAIT_C)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .laptop_img_rdy(laptop_img_rdy),
        .win_ready     (win_ready),
        .pipe_idle     (pipe_idle),
        .win_valid     (win_valid),
        .img_index     (img_index),
        .row_index     (row_index),
        .col_index     (col_index),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [67:0] act, input logic [67:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Hand-computed window order for the two-level table.
    task automatic push_frame();
`ifdef VJ_SCHED_STRIDE2_EN
        sb.push_back('{4'd0, 32'd0, 32'd0});
        sb.push_back('{4'd0, 32'd0, 32'd2});
        sb.push_back('{4'd1, 32'd0, 32'd0});
`else
        sb.push_back('{4'd0, 32'd0, 32'd0});
        sb.push_back('{4'd0, 32'd0, 32'd1});
        sb.push_back('{4'd0, 32'd0, 32'd2});
        sb.push_back('{4'd0, 32'd1, 32'd0});
        sb.push_back('{4'd0, 32'd1, 32'd1});
        sb.push_back('{4'd0, 32'd1, 32'd2});
        sb.push_back('{4'd1, 32'd0, 32'd0});
        sb.push_back('{4'd1, 32'd0, 32'd1});
`endif
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 68'(win_valid), 68'(0));
        check({tag, "_img"},   68'(img_index), 68'(15));
        check({tag, "_row"},   68'(row_index), 68'(0));
        check({tag, "_col"},   68'(col_index), 68'(0));
        check({tag, "_busy"},  68'(busy),      68'(0));
        check({tag, "_done"},  68'(done),      68'(0));
    endtask

    // Monitor: pops the scoreboard on each handshake, checks stall hold and done width.
    always @(negedge clock) begin : mon
        static logic prev_stall = 1'b0;
        static logic prev_done  = 1'b0;
        static win_t prev_win   = '0;
        win_t act;
        win_t exp;
        act = {img_index, row_index, col_index};
        if (reset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall && win_valid)
                check("hold_on_stall", act, prev_win);
            if (win_valid && win_ready) begin
                hs_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL window: unexpected window %0h with empty scoreboard", act);
                end else begin
                    exp = sb.pop_front();
                    check("window", act, exp);
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_one_cycle", 68'(prev_done), 68'(0));
            end
            prev_stall = win_valid && !win_ready;
            prev_win   = act;
            prev_done  = done;
        end
    end

    // Pulses start, checks settle latency, then drives win_ready until all windows are consumed.
    task automatic start_and_scan(input int mode, input bit extra);
        int n;
        push_frame();
        laptop_img_rdy = 1'b1;
        @(posedge clock); #1;
        laptop_img_rdy = 1'b0;
        check("busy_after_start", 68'(busy), 68'(1));
        n = 0;
        while (!win_valid && n < 20) begin
            laptop_img_rdy = extra && (n == 1);
            @(posedge clock); #1;
            n++;
        end
        laptop_img_rdy = 1'b0;
        check("start_latency", 68'(n), 68'(WAIT_C));
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            win_ready      = (mode == 0) ? 1'b1 : ((n % 3) == 0);
            laptop_img_rdy = extra && (n == 2);
            @(posedge clock); #1;
            n++;
        end
        laptop_img_rdy = 1'b0;
        check("all_windows_consumed", 68'(sb.size()), 68'(0));
    endtask

    task automatic run_frame(input int mode, input int idle_hold, input bit extra, input bit restart);
        int start_done;
        int m;
        start_done = done_cnt;
        start_and_scan(mode, extra);
        win_ready = 1'b0;
        for (int i = 0; i < idle_hold; i++) begin
            @(posedge clock); #1;
            check("drain_busy", 68'(busy), 68'(1));
            check("drain_no_done", 68'(done), 68'(0));
        end
        pipe_idle = 1'b1;
        m = 0;
        while (!done && m < 20) begin
            @(posedge clock); #1;
            m++;
        end
        check("done_seen", 68'(done), 68'(1));
        if (restart) begin
            laptop_img_rdy = 1'b1;
            @(posedge clock); #1;
            laptop_img_rdy = 1'b0;
            check("start_with_done", 68'(busy), 68'(1));
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
        end
        repeat (3) @(posedge clock);
        #1;
        check("done_count", 68'(done_cnt - start_done), 68'(1));
        check("idle_img", 68'(img_index), 68'(15));
        check("idle_busy", 68'(busy), 68'(0));
        if (mode == 0 && idle_hold == 0 && !restart)
            check("done_delay", 68'(done_cyc - hs_cyc), 68'(2));
    endtask

    initial begin
        int n;
        int d0;
        reset          = 1'b1;
        laptop_img_rdy = 1'b0;
        win_ready      = 1'b0;
        pipe_idle      = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_idle("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        win_ready = 1'b1;
        run_frame(0, 0, 1'b0, 1'b0);

        run_frame(1, 0, 1'b0, 1'b0);

        pipe_idle = 1'b0;
        win_ready = 1'b1;
        run_frame(0, 10, 1'b0, 1'b0);

        // Abort mid-frame with reset while the fourth window is presented.
        d0 = done_cnt;
        win_ready = 1'b1;
        push_frame();
        laptop_img_rdy = 1'b1;
        @(posedge clock); #1;
        laptop_img_rdy = 1'b0;
        n = 0;
        while (sb.size() > (8 - 3) && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
`ifndef VJ_SCHED_STRIDE2_EN
        check("abort_on_fourth", 68'(win_valid), 68'(1));
`endif
        reset = 1'b1;
        #1;
        check_idle("abort");
        sb.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("abort_no_done", 68'(done_cnt - d0), 68'(0));
        run_frame(0, 0, 1'b0, 1'b0);

        win_ready = 1'b1;
        run_frame(0, 0, 1'b1, 1'b0);

        win_ready = 1'b1;
        run_frame(0, 0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vj_scan_scheduler.md
# vj_scan_scheduler

Sequencer that drives the Viola-Jones scanning-window datapath across all pyramid levels. After an image-ready pulse it waits a fixed integral-image settle time, then issues one window coordinate (pyramid level, row, column) per accepted handshake to the classifier pipeline. When the last window is accepted, it waits for the pipeline to drain and pulses `done`. It takes over the inline scan FSM in the top level and adds back-pressure so the pipeline may stall.

## Interface
Parameters:
- `PYRAMID_LEVELS`, default `PYRAMID_LEVELS` (10): number of levels; at most 15.
- `WINDOW_SIZE`, default `WINDOW_SIZE` (24): square window edge, in pixels.
- `LEVEL_WIDTHS`, default `PYRAMID_WIDTHS`: packed `[PYRAMID_LEVELS-1:0][31:0]`; element `[i]` is the width of level i.
- `LEVEL_HEIGHTS`, default `PYRAMID_HEIGHTS`: packed `[PYRAMID_LEVELS-1:0][31:0]`; element `[i]` is the height of level i.
- `INT_WAIT_CYCLES`, default 76800: settle cycles between start and the first window; must be at least 1.

Ports:
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `laptop_img_rdy` in 1: start pulse; sampled only in IDLE.
- `win_ready` in 1: pipeline accepts the presented window.
- `pipe_idle` in 1: pipeline holds no in-flight windows.
- `win_valid` out 1: a window coordinate is presented.
- `img_index` out 4: current level; 4'd15 when not scanning.
- `row_index` out 32: window top row.
- `col_index` out 32: window left column.
- `busy` out 1: the FSM is not in IDLE.
- `done` out 1: one-cycle pulse at the end of a frame.

## Operation
- States and transitions:
  - IDLE: `laptop_img_rdy` → WAIT_INT, with `wait_cnt` set to 0.
  - WAIT_INT: `wait_cnt` increments each cycle; at `wait_cnt == INT_WAIT_CYCLES-1` → SCAN, with level, row and column set to 0.
  - SCAN: `win_valid` = 1. Indices advance only on an edge where `win_valid && win_ready`.
  - DRAIN: `win_valid` = 0; `pipe_idle` → IDLE.
- Advance rule for step S (S = 1, or 2 under the configuration macro):
  - If `col+S <= W[lvl]-WINDOW_SIZE`: `col += S`.
  - Else if `row+S <= H[lvl]-WINDOW_SIZE`: `col = 0`, `row += S`.
  - Else if `lvl < PYRAMID_LEVELS-1`: `lvl += 1`, `row = col = 0`.
  - Else this was the last window: → DRAIN.
- `img_index`, `row_index` and `col_index` hold their values while `win_ready` is low. `win_valid` never drops in SCAN until the last window is accepted.
- Level-table comparisons use 32-bit unsigned arithmetic. A level with W or H below `WINDOW_SIZE` is a configuration error and is not checked.
- Outside SCAN: `img_index` = 15 and row = col = 0.
- `laptop_img_rdy` outside IDLE is ignored; frames are never queued.
- The output index registers hold the value presented, so there is no combinational path from `win_ready` to the indices.

## Timing
- Reset values: IDLE, `win_valid` = 0, `img_index` = 15, `row_index` = 0, `col_index` = 0, `busy` = 0, `done` = 0, `wait_cnt` = 0.
- Reset asserted mid-frame aborts immediately to the reset values. No `done` is produced for the aborted frame.
- Start latency: `win_valid` first rises exactly `INT_WAIT_CYCLES` edges after the edge that samples `laptop_img_rdy`.
- Throughput: one window per cycle while `win_ready` is held high.
- `done`: registered, high for exactly the one cycle following the DRAIN→IDLE edge.
  - If `pipe_idle` is already high at the DRAIN entry edge, the FSM leaves DRAIN on the next edge.
  - A `laptop_img_rdy` coincident with `done` high is accepted, since the FSM is in IDLE.
- `busy` = 1 in WAIT_INT, SCAN and DRAIN.

## Configuration
- `VJ_SCHED_STRIDE2_EN`:
  - Defined: S = 2 for both rows and columns, so the last position per row is the largest even column ≤ W−`WINDOW_SIZE`, and likewise for rows.
  - Undefined: S = 1, giving an exhaustive scan.
  - Level sequencing, handshake and timing are otherwise identical.

## Test plan
All scenarios use `PYRAMID_LEVELS`=2, widths {26,25}, heights {25,24}, `WINDOW_SIZE`=24, `INT_WAIT_CYCLES`=4.
- Start pulse with `win_ready` held 1 and `pipe_idle` 1 → `win_valid` rises 4 edges after start. Sequence (lvl,row,col): (0,0,0) (0,0,1) (0,0,2) (0,1,0) (0,1,1) (0,1,2) (1,0,0) (1,0,1), 8 handshakes. `done` pulses 2 cycles after the last handshake.
- Same run with `win_ready` toggling 1,0,0,1… → indices hold during low cycles, the same 8-tuple order results, and there are no duplicates.
- `pipe_idle` held 0 for 10 cycles after the last handshake → `busy` stays 1 and `done` = 0 until `pipe_idle` rises. `done` then pulses once.
- Reset asserted on the 4th handshake → outputs return to their reset values in the same cycle. A new start then replays from (0,0,0).
- `laptop_img_rdy` pulsed during WAIT_INT and SCAN → ignored; the frame completes with 8 windows and a single `done`.
- With `VJ_SCHED_STRIDE2_EN` defined → sequence (0,0,0) (0,0,2) (1,0,0), followed by `done`.
